fp_add_sequencer: RTL and testbench



---
 rtl/fp_add_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP32 adder: compare/swap, right-shift alignment, add/sub and normalization as FSM steps.
// Define FP_ADD_SEQ_FAST_ALIGN_EN to replace the 1-bit-per-cycle aligner with a single-cycle barrel shift.
module fp_add_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [DATA_WIDTH-1:0] floating1_in,
  input  logic [DATA_WIDTH-1:0] floating2_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  busy_out
);
  localparam int MW = MENT_WIDTH + 1;
  localparam int SW = MENT_WIDTH + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_COMPARE, ST_SPECIAL, ST_ALIGN, ST_ADD, ST_NORM, ST_DONE
  } state_t;

  state_t                  state_q;
  logic                    in_ready_q, out_valid_q, busy_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [DATA_WIDTH-1:0]   op1_q, op2_q;
  logic                    sign_q, sub_q;
  logic [EXPO_WIDTH-1:0]   exp_q;
  logic [MW-1:0]           mant_a_q, mant_b_q;
  logic [SW-1:0]           sum_q;
  logic [CW-1:0]           shift_q;

  function automatic logic [DATA_WIDTH-1:0] pack_fp(input logic s, input logic [EXPO_WIDTH-1:0] e,
                                                    input logic [MENT_WIDTH-1:0] f);
    return {s, e, f};
  endfunction

  // Beyond SW positions every mantissa bit is shifted out, so larger distances saturate.
  function automatic logic [CW-1:0] clamp_shift(input logic [EXPO_WIDTH-1:0] diff);
    return (diff > EXPO_WIDTH'(SW)) ? CW'(SW) : CW'(diff);
  endfunction

  logic                  s1, s2, z1, z2, a_first, is_spec;
  logic [EXPO_WIDTH-1:0] e1, e2;
  logic [MW-1:0]         m1, m2;
  logic [DATA_WIDTH-1:0] spec_res;

  always_comb begin
    s1 = op1_q[DATA_WIDTH-1];
    s2 = op2_q[DATA_WIDTH-1];
    e1 = op1_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    e2 = op2_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    z1 = (e1 == '0);
    z2 = (e2 == '0);
    m1 = z1 ? '0 : {1'b1, op1_q[MENT_WIDTH-1:0]};
    m2 = z2 ? '0 : {1'b1, op2_q[MENT_WIDTH-1:0]};
    a_first = (e1 > e2) || ((e1 == e2) && (m1 >= m2));
    is_spec = (e1 == EXP_MAX) || (e2 == EXP_MAX) || z1 || z2;
    if (e1 == EXP_MAX)      spec_res = op1_q;
    else if (e2 == EXP_MAX) spec_res = op2_q;
    else if (z1 && z2)      spec_res = pack_fp(s1 & s2, '0, '0);
    else if (z1)            spec_res = op2_q;
    else                    spec_res = op1_q;
  end

  logic                  norm_done;
  logic [DATA_WIDTH-1:0] norm_res;
  logic [SW-1:0]         norm_sum;
  logic [EXPO_WIDTH-1:0] norm_exp;

  // One normalization step; the shifted value is checked in the same cycle so n shifts cost n cycles.
  always_comb begin
    norm_done = 1'b0;
    norm_res  = '0;
    norm_sum  = sum_q;
    norm_exp  = exp_q;
    if (sum_q == '0) begin
      norm_done = 1'b1;
    end else if (sum_q[SW-1]) begin
      norm_sum  = sum_q >> 1;
      norm_exp  = exp_q + EXPO_WIDTH'(1);
      norm_done = 1'b1;
      norm_res  = (norm_exp == EXP_MAX) ? pack_fp(sign_q, EXP_MAX, '0)
                                        : pack_fp(sign_q, norm_exp, norm_sum[MENT_WIDTH-1:0]);
    end else if (!sum_q[MENT_WIDTH]) begin
      norm_sum = sum_q << 1;
      norm_exp = exp_q - EXPO_WIDTH'(1);
      if (norm_exp == '0) begin
        norm_done = 1'b1;
        norm_res  = pack_fp(sign_q, '0, '0);
      end else if (norm_sum[MENT_WIDTH]) begin
        norm_done = 1'b1;
        norm_res  = pack_fp(sign_q, norm_exp, norm_sum[MENT_WIDTH-1:0]);
      end
    end else begin
      norm_done = 1'b1;
      norm_res  = pack_fp(sign_q, exp_q, sum_q[MENT_WIDTH-1:0]);
    end
  end

  // Datapath registers: no reset, qualified by the control state.
  always_ff @(posedge clk_in) begin
    case (state_q)
      ST_IDLE: begin
        if (in_valid_in) begin
          op1_q <= floating1_in;
          op2_q <= floating2_in;
        end
      end
      ST_COMPARE: begin
        sign_q   <= a_first ? s1 : s2;
        sub_q    <= s1 ^ s2;
        exp_q    <= a_first ? e1 : e2;
        mant_a_q <= a_first ? m1 : m2;
        mant_b_q <= a_first ? m2 : m1;
        shift_q  <= a_first ? clamp_shift(e1 - e2) : clamp_shift(e2 - e1);
      end
      ST_ALIGN: begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
        mant_b_q <= mant_b_q >> shift_q;
        shift_q  <= '0;
`else
        mant_b_q <= mant_b_q >> 1;
        shift_q  <= shift_q - CW'(1);
`endif
      end
      ST_ADD: begin
        sum_q <= sub_q ? ({1'b0, mant_a_q} - {1'b0, mant_b_q})
                       : ({1'b0, mant_a_q} + {1'b0, mant_b_q});
      end
      ST_NORM: begin
        sum_q <= norm_sum;
        exp_q <= norm_exp;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_in) begin
            state_q    <= ST_COMPARE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_COMPARE: begin
          if (is_spec) begin
            result_q <= spec_res;
            state_q  <= ST_SPECIAL;
          end else if ((a_first ? clamp_shift(e1 - e2) : clamp_shift(e2 - e1)) != '0) begin
            state_q <= ST_ALIGN;
          end else begin
            state_q <= ST_ADD;
          end
        end
        // Special results are already packed; this cycle keeps their latency fixed at two edges.
        ST_SPECIAL: begin
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
        end
        ST_ALIGN: begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
          state_q <= ST_ADD;
`else
          if (shift_q == CW'(1)) state_q <= ST_ADD;
`endif
        end
        ST_ADD: state_q <= ST_NORM;
        ST_NORM: begin
          if (norm_done) begin
            result_q    <= norm_res;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready_in) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_out  = in_ready_q;
  assign out_valid_out = out_valid_q;
  assign busy_out      = busy_q;
  assign result_out    = result_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer: directed FP32 vectors with hand-computed sums and latencies.
module tb_fp_add_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] f1 = '0, f2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] res; int due; } exp_t;
  exp_t sb_q[$];

`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
  localparam int LAT_D24 = 4;
`else
  localparam int LAT_D24 = 27;
`endif

  fp_add_sequencer dut (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(in_ready),
    .floating1_in(f1), .floating2_in(f2), .out_valid_out(out_valid), .out_ready_in(out_ready),
    .result_out(result), .busy_out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    f1 = a; f2 = b; in_valid = 1'b1;
    @(posedge clk);
    step();
    in_valid = 1'b0;
    if (push) sb_q.push_back('{res: res, due: cyc + lat});
  endtask

  // Monitor: pops on each rising out_valid, and checks hold stability and handshake completion.
  initial begin : monitor
    logic        prev_valid = 1'b0;
    logic [31:0] held = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && out_ready) begin
          check("hs_valid_falls", {31'b0, out_valid}, 32'd0);
          check("hs_ready_rises", {31'b0, in_ready}, 32'd1);
        end else if (out_valid && !prev_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_result", result, 32'hxxxxxxxx);
          end else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("latency", cyc, e.due);
            check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
          end
          held = result;
        end else if (out_valid && prev_valid) begin
          check("hold_result_stable", result, held);
          check("hold_in_ready_low", {31'b0, in_ready}, 32'd0);
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin : driver
    int n;
    repeat (3) step();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;
    step();

    issue(32'h3F800000, 32'h3F800000, 32'h40000000, 3, 1);
    step();
    check("busy_during_op", {31'b0, busy}, 32'd1);
    issue(32'h40000000, 32'h3F800000, 32'h40400000, 4, 1);
    issue(32'h3F800000, 32'h40000000, 32'h40400000, 4, 1);
    issue(32'h3FC00000, 32'hBF800000, 32'h3F000000, 3, 1);
    issue(32'h3F800000, 32'hBF800000, 32'h00000000, 3, 1);
    issue(32'h4B800000, 32'h3F800000, 32'h4B800000, LAT_D24, 1);
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 3, 1);
    issue(32'h7F800000, 32'h3F800000, 32'h7F800000, 2, 1);
    issue(32'h80000000, 32'h80000000, 32'h80000000, 2, 1);
    issue(32'h3F800000, 32'h00000000, 32'h3F800000, 2, 1);
    issue(32'h3F800001, 32'hBF800000, 32'h34000000, 25, 1);
    issue(32'hC0000000, 32'hBF800000, 32'hC0400000, 4, 1);

    // Consumer stalls for 10 cycles in DONE.
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, 3, 1);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    check("stall_reached_done", {31'b0, out_valid}, 32'd1);
    repeat (10) step();
    out_ready = 1'b1;
    step();

    // Abort a long alignment with reset.
    issue(32'h4B800000, 32'h3F800000, 32'h4B800000, LAT_D24, 0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_result", result, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(32'h40000000, 32'h3F800000, 32'h40400000, 4, 1);

    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin step(); n++; end
    check("drain_queue_empty", sb_q.size(), 32'd0);
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
